// File: rtl/eot_pkg.sv
// eot_pkg: shared definitions for the end-of-transfer marker generator and
// decoder.
//   EOT_EOL / EOT_EOF : bit positions inside the 2-bit EOT field
//   eot_t             : the EOT field itself
//   eot_err_t         : marker-check error flags, packed to match err[3:0]
//   EOT_CHECK_EN      : 1 when the build defines EOT_DEC_CHECK_EN
package eot_pkg;

    localparam int EOT_EOL = 0;   // last beat of a row
    localparam int EOT_EOF = 1;   // last beat of a feature window

    typedef logic [1:0] eot_t;

    // Declared MSB first so that bit 0 is eol_early.
    typedef struct packed {
        logic eof_missing;  // [3] window forced closed at last row/column
        logic eof_early;    // [2] window marker before the last row
        logic eol_missing;  // [1] row forced closed at last column
        logic eol_early;    // [0] row marker before the last column
    } eot_err_t;

`ifdef EOT_DEC_CHECK_EN
    localparam bit EOT_CHECK_EN = 1'b1;
`else
    localparam bit EOT_CHECK_EN = 1'b0;
`endif

endpackage

// File: rtl/eot_dec_pos.sv
// eot_dec_pos: window position tracker for eot_dec.
// Holds the column/row counters, tags the current beat and works out the
// row/window close and marker errors for it. Counters move only on adv.
//   clk, rst      : clock, synchronous active-high reset
//   adv           : input handshake, advance the counters
//   eot           : EOT field of the current beat
//   x, y          : position of the current beat
//   sof, eol, eof : flags for the current beat (combinational)
//   err_det       : marker errors for the current beat (combinational)
module eot_dec_pos
    import eot_pkg::*;
#(
    parameter int FEATURE_WIDTH  = 24,
    parameter int FEATURE_HEIGHT = 24,
    parameter int XW             = $clog2(FEATURE_WIDTH),
    parameter int YW             = $clog2(FEATURE_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          adv,
    input  eot_t          eot,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          sof,
    output logic          eol,
    output logic          eof,
    output eot_err_t      err_det
);

    localparam logic [XW-1:0] X_LAST = XW'(FEATURE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(FEATURE_HEIGHT - 1);

    logic last_x, last_y, mark_eol;

    assign last_x   = (x == X_LAST);
    assign last_y   = (y == Y_LAST);
    assign mark_eol = eot[EOT_EOL] | eot[EOT_EOF];

    // The last column always closes its row; the last column of the last
    // row always closes the window, marked or not.
    assign sof = (x == '0) && (y == '0);
    assign eol = mark_eol | last_x;
    assign eof = eot[EOT_EOF] | (last_x & last_y);

    assign err_det.eol_early   = mark_eol & ~last_x;
    assign err_det.eol_missing = last_x & ~mark_eol;
    assign err_det.eof_early   = eot[EOT_EOF] & ~last_y;
    assign err_det.eof_missing = last_x & last_y & ~eot[EOT_EOF];

    // Markers always resynchronise: an early row/window close restarts
    // tracking at column 0 of the next row / of row 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (adv) begin
            if (eol) begin
                x <= '0;
                y <= (eof || last_y) ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/eot_dec.sv
// eot_dec: decodes a valid/ready pixel stream carrying 2-bit EOT markers into
// per-beat window coordinates and start/end-of-line/end-of-frame flags.
// One output register; 1-cycle latency, full throughput.
// Build option EOT_DEC_CHECK_EN: when defined, marker placement is checked
// and reported on sticky err[3:0]; otherwise err is 0 and err_clr unused.
//   clk, rst           : clock, synchronous active-high reset
//   din_valid/ready    : input handshake
//   din_data, din_eot  : pixel and EOT field ([0] end of row, [1] end of window)
//   dout_valid/ready   : output handshake
//   dout_data/x/y      : registered pixel and its window position
//   dout_sof/eol/eof   : beat is (0,0) / closes a row / closes a window
//   frame_cnt          : completed windows (wrapping)
//   err_clr, err       : clear / sticky {eof_missing, eof_early, eol_missing, eol_early}
module eot_dec
    import eot_pkg::*;
#(
    parameter int FEATURE_WIDTH  = 24,
    parameter int FEATURE_HEIGHT = 24,
    parameter int W_DATA         = 8,
    parameter int W_FCNT         = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              din_valid,
    output logic                              din_ready,
    input  logic [W_DATA-1:0]                 din_data,
    input  logic [1:0]                        din_eot,
    output logic                              dout_valid,
    input  logic                              dout_ready,
    output logic [W_DATA-1:0]                 dout_data,
    output logic [$clog2(FEATURE_WIDTH)-1:0]  dout_x,
    output logic [$clog2(FEATURE_HEIGHT)-1:0] dout_y,
    output logic                              dout_sof,
    output logic                              dout_eol,
    output logic                              dout_eof,
    output logic [W_FCNT-1:0]                 frame_cnt,
    input  logic                              err_clr,
    output logic [3:0]                        err
);

    localparam int XW = $clog2(FEATURE_WIDTH);
    localparam int YW = $clog2(FEATURE_HEIGHT);

    logic          hs;
    logic [XW-1:0] pos_x;
    logic [YW-1:0] pos_y;
    logic          pos_sof, pos_eol, pos_eof;
    eot_err_t      err_det;

    // Output register is free or being drained this cycle.
    assign din_ready = ~dout_valid | dout_ready;
    assign hs        = din_valid & din_ready;

    eot_dec_pos #(
        .FEATURE_WIDTH (FEATURE_WIDTH),
        .FEATURE_HEIGHT(FEATURE_HEIGHT),
        .XW            (XW),
        .YW            (YW)
    ) u_pos (
        .clk    (clk),
        .rst    (rst),
        .adv    (hs),
        .eot    (din_eot),
        .x      (pos_x),
        .y      (pos_y),
        .sof    (pos_sof),
        .eol    (pos_eol),
        .eof    (pos_eof),
        .err_det(err_det)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid <= 1'b0;
            dout_data  <= '0;
            dout_x     <= '0;
            dout_y     <= '0;
            dout_sof   <= 1'b0;
            dout_eol   <= 1'b0;
            dout_eof   <= 1'b0;
            frame_cnt  <= '0;
        end else if (hs) begin
            dout_valid <= 1'b1;
            dout_data  <= din_data;
            dout_x     <= pos_x;
            dout_y     <= pos_y;
            dout_sof   <= pos_sof;
            dout_eol   <= pos_eol;
            dout_eof   <= pos_eof;
            if (pos_eof)
                frame_cnt <= frame_cnt + W_FCNT'(1);
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

`ifdef EOT_DEC_CHECK_EN
    logic [3:0] err_q;
    logic [3:0] err_new;

    assign err_new = hs ? err_det : 4'b0000;

    // Clear first, then OR in this cycle's errors so a new error survives a
    // simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 4'b0000;
        else
            err_q <= (err_clr ? 4'b0000 : err_q) | err_new;
    end

    assign err = err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{err_clr, err_det};
    assign err = 4'b0000;
`endif

endmodule
